// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit multiplexed seven-segment scan controller: accepts a 14-bit value,
// converts it to BCD with a sequential double-dabble engine, scans digits.
module seven_seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] value_bin,
  input  logic        blank,
  output logic [3:0]  digit_num,
  output logic [3:0]  digit_en_n,
  output logic        overflow
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e      state_q;
  logic        rdy_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic        ovf_pend_q;
  logic [15:0] disp_q;
  logic        ovf_q;

  // Add-3 correction on every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q      <= value_bin;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (value_bin > 14'd9999);
            rdy_q      <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= {bcd_adj[14:0], bin_q[13]};
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state_q <= COMMIT;
        end
        COMMIT: begin
          // Display and overflow update together so the scan never sees a mix.
          disp_q  <= bcd_q;
          ovf_q   <= ovf_pend_q;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign overflow = ovf_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  logic lead_zero;
  always_comb begin
    case (idx_q)
      2'd1:    lead_zero = (disp_q[15:4] == 12'd0);
      2'd2:    lead_zero = (disp_q[15:8] == 8'd0);
      2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  // Priority: blank > overflow > leading-zero suppression > normal digit.
  always_comb begin
    digit_en_n = ~(4'b0001 << idx_q);
    digit_num  = disp_q[4*idx_q +: 4];
    if (BLANK_LEADING && lead_zero) begin
      digit_en_n = 4'hF;
      digit_num  = 4'hF;
    end
    if (ovf_q) begin
      digit_en_n = ~(4'b0001 << idx_q);
      digit_num  = 4'hF;
    end
    if (blank) begin
      digit_en_n = 4'hF;
      digit_num  = 4'hF;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: decimal-arithmetic reference model, vector table,
// corner-case sequences and randomized traffic on two blanking variants.
module tb_seven_seg_scan_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] value_bin;
  logic        blank;
  logic        in_ready_a, overflow_a, in_ready_b, overflow_b;
  logic [3:0]  num_a, en_a, num_b, en_b;

  int nchk = 0;
  int nerr = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .value_bin(value_bin), .blank(blank), .digit_num(num_a),
    .digit_en_n(en_a), .overflow(overflow_a));

  seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .value_bin(value_bin), .blank(blank), .digit_num(num_b),
    .digit_en_n(en_b), .overflow(overflow_b));

  // Reference model: cycle count since reset, countdown to commit, decimal value.
  int mcyc, busy, capv, disp;
  bit movf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcyc = 0; busy = 0; capv = 0; disp = 0; movf = 1'b0;
    end else begin
      mcyc++;
      if (busy == 0) begin
        if (in_valid) begin
          capv = int'(value_bin);
          busy = 15;
        end
      end else begin
        busy--;
        if (busy == 0) begin
          disp = capv;
          movf = (capv > 9999);
        end
      end
    end
  end

  function automatic int cur_idx();
    return (mcyc / DIV) % 4;
  endfunction

  function automatic void model_out(input int v, input bit ov, input bit bl, input bit blz,
                                    input int idx, output logic [3:0] en, output logic [3:0] num);
    int pw;
    pw = 1;
    for (int i = 0; i < idx; i++) pw = pw * 10;
    num = 4'((v / pw) % 10);
    en = 4'hF;
    en[idx] = 1'b0;
    if (blz && idx > 0 && v < pw) begin
      en = 4'hF;
      num = 4'hF;
    end
    if (ov) begin
      en = 4'hF;
      en[idx] = 1'b0;
      num = 4'hF;
    end
    if (bl) begin
      en = 4'hF;
      num = 4'hF;
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e_en, e_num;
    #2;
    if (run_chk) begin
      chk("ready_a", 16'(in_ready_a), 16'(busy == 0));
      chk("ready_b", 16'(in_ready_b), 16'(busy == 0));
      chk("ovf_a", 16'(overflow_a), 16'(movf));
      chk("ovf_b", 16'(overflow_b), 16'(movf));
      model_out(disp, movf, blank, 1'b1, cur_idx(), e_en, e_num);
      chk("en_a", 16'(en_a), 16'(e_en));
      chk("num_a", 16'(num_a), 16'(e_num));
      model_out(disp, movf, blank, 1'b0, cur_idx(), e_en, e_num);
      chk("en_b", 16'(en_b), 16'(e_en));
      chk("num_b", 16'(num_b), 16'(e_num));
    end
  end

  typedef struct {
    int          v;
    logic        ov;
    logic [15:0] num1, en1, num0, en0;  // per-slot nibbles, slot 0 in the LSBs
  } vec_t;
  vec_t vecs[7];

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", 16'(k < 100), 16'd1);
  endtask

  task automatic send(input int v);
    wait_ready();
    in_valid = 1'b1;
    value_bin = 14'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int k, s;
    vecs[0] = '{1234,  1'b0, 16'h1234, 16'h7BDE, 16'h1234, 16'h7BDE};
    vecs[1] = '{0,     1'b0, 16'hFFF0, 16'hFFFE, 16'h0000, 16'h7BDE};
    vecs[2] = '{42,    1'b0, 16'hFF42, 16'hFFDE, 16'h0042, 16'h7BDE};
    vecs[3] = '{10000, 1'b1, 16'hFFFF, 16'h7BDE, 16'hFFFF, 16'h7BDE};
    vecs[4] = '{9999,  1'b0, 16'h9999, 16'h7BDE, 16'h9999, 16'h7BDE};
    vecs[5] = '{1005,  1'b0, 16'h1005, 16'h7BDE, 16'h1005, 16'h7BDE};
    vecs[6] = '{100,   1'b0, 16'hF100, 16'hFBDE, 16'h0100, 16'h7BDE};

    rst_n = 1'b0; in_valid = 1'b0; value_bin = '0; blank = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ready", 16'(in_ready_a), 16'd1);
    chk("rst_en", 16'(en_a), 16'hE);
    chk("rst_num", 16'(num_a), 16'h0);
    chk("rst_ovf", 16'(overflow_a), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    repeat (20) @(negedge clk);

    // Table: commit each value, then observe a full scan round on both variants.
    foreach (vecs[n]) begin
      send(vecs[n].v);
      repeat (16) @(negedge clk);
      for (int c = 0; c < 4 * DIV; c++) begin
        @(negedge clk);
        #2;
        s = cur_idx();
        chk("tbl_ovf", 16'(overflow_a), 16'(vecs[n].ov));
        chk("tbl_num1", 16'(num_a), 16'(vecs[n].num1[4*s +: 4]));
        chk("tbl_en1", 16'(en_a), 16'(vecs[n].en1[4*s +: 4]));
        chk("tbl_num0", 16'(num_b), 16'(vecs[n].num0[4*s +: 4]));
        chk("tbl_en0", 16'(en_b), 16'(vecs[n].en0[4*s +: 4]));
      end
    end

    // Back-to-back with in_valid held: next accept exactly 16 cycles later.
    wait_ready();
    in_valid = 1'b1; value_bin = 14'd9999;
    @(negedge clk);
    value_bin = 14'd0;
    chk("b2b_busy", 16'(in_ready_a), 16'd0);
    k = 1;
    while (!in_ready_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_gap", 16'(k), 16'd16);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second", 16'(in_ready_a), 16'd0);
    repeat (20) @(negedge clk);

    // Blank mid-scan: dark for 10 cycles, scan position keeps advancing.
    send(1234);
    repeat (18) @(negedge clk);
    blank = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #2;
      chk("blank_en", 16'(en_a), 16'hF);
      chk("blank_num", 16'(num_a), 16'hF);
    end
    @(negedge clk);
    blank = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during conversion discards the value and clears the display.
    send(5678);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", 16'(in_ready_a), 16'd1);
    chk("mid_rst_en", 16'(en_a), 16'hE);
    chk("mid_rst_num", 16'(num_a), 16'h0);
    chk("mid_rst_ovf", 16'(overflow_a), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom % 4 == 0);
      value_bin = ($urandom % 3 == 0) ? 14'($urandom_range(0, 16383))
                                      : 14'($urandom_range(0, 9999));
      if ($urandom % 20 == 0) value_bin = 14'($urandom_range(0, 9));
      blank = ($urandom % 16 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; blank = 1'b0;
    repeat (20) @(negedge clk);
    run_chk = 1'b0;
    #3;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
